// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and the default word width
// used by both the transmitter and the receiver.
package spi_pkg;

   localparam int SPI_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous input, with a programmable
// reset level and rise/fall detection on the synchronized value.
module spi_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] ff;
   logic                   prev;

   // Shift the pin through the stages and remember last synchronized value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ff   <= {SYNC_STAGES{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         ff   <= {ff[SYNC_STAGES-2:0], d};
         prev <= ff[SYNC_STAGES-1];
      end
   end

   assign q    = ff[SYNC_STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/spi_rx.sv
// SPI receiver: oversamples scl/sda/cs, shifts in MSB-first words and hands
// them downstream through a valid/rd_ack handshake, flagging framing errors
// and overruns.
//
// state | meaning
// IDLE  | waiting for cs low, counter and shift register cleared
// RECV  | frame active, shifting one bit per scl rise
// DONE  | one cycle: publish the word, then continue or return to IDLE
module spi_rx
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scl,
   input  logic                  sda,
   input  logic                  cs,
   input  logic                  rd_ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic scl_rise, sda_s, cs_s;
   logic scl_q_unused, scl_fall_unused;
   logic sda_rise_unused, sda_fall_unused;
   logic cs_rise_unused, cs_fall_unused;

   spi_state_t             state, next_state;
   logic [DATA_WIDTH-1:0]  shift;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   do_shift, do_ferr, do_load, clr_cnt, clr_shift;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scl (
      .clk(clk), .reset(reset), .d(scl),
      .q(scl_q_unused), .rise(scl_rise), .fall(scl_fall_unused)
   );

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sda (
      .clk(clk), .reset(reset), .d(sda),
      .q(sda_s), .rise(sda_rise_unused), .fall(sda_fall_unused)
   );

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .d(cs),
      .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and datapath strobes; a cs release outranks a same-cycle scl rise.
   always_comb begin
      next_state = state;
      do_shift   = 1'b0;
      do_ferr    = 1'b0;
      do_load    = 1'b0;
      clr_cnt    = 1'b0;
      clr_shift  = 1'b0;
      case (state)
         IDLE: begin
            clr_cnt   = 1'b1;
            clr_shift = 1'b1;
            if (!cs_s) next_state = RECV;
         end
         RECV: begin
            if (cs_s) begin
               clr_cnt    = 1'b1;
               clr_shift  = 1'b1;
               do_ferr    = (bit_cnt != '0);
               next_state = IDLE;
            end else if (scl_rise) begin
               do_shift = 1'b1;
               if (bit_cnt == LAST_BIT) next_state = DONE;
            end
         end
         DONE: begin
            do_load    = 1'b1;
            clr_cnt    = 1'b1;
            next_state = cs_s ? IDLE : RECV;
         end
         default: next_state = IDLE;
      endcase
   end

   // Shift register and bit counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift   <= '0;
         bit_cnt <= '0;
      end else begin
         if (do_shift) begin
            shift   <= {shift[DATA_WIDTH-2:0], sda_s};
            bit_cnt <= bit_cnt + 1'b1;
         end else begin
            if (clr_shift) shift   <= '0;
            if (clr_cnt)   bit_cnt <= '0;
         end
      end
   end

   // Output word, handshake and one-cycle status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out  <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= do_ferr;
         overrun   <= do_load & valid & ~rd_ack;
         if (do_load) begin
            data_out <= shift;
            valid    <= 1'b1;
         end else if (valid && rd_ack) begin
            valid    <= 1'b0;
         end
      end
   end

   assign busy = (state == RECV);

endmodule

// File: tb/tb_spi_rx.sv
// Directed plus randomized bench for spi_rx. Pins are driven on the falling
// clock edge; outputs are sampled on the falling edge.
module tb_spi_rx;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       scl    = 1'b1;
   logic       sda    = 1'b1;
   logic       cs     = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] data_out;
   logic       valid, frame_err, overrun, busy;

   int total    = 0;
   int passed   = 0;
   int ferr_cyc = 0;
   int ovr_cyc  = 0;
   int exp_ferr = 0;
   int exp_ovr  = 0;
   bit model_valid = 1'b0;

   spi_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .scl(scl), .sda(sda), .cs(cs),
      .rd_ack(rd_ack), .data_out(data_out), .valid(valid),
      .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) ferr_cyc++;
      if (overrun === 1'b1)   ovr_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      int lo, hi;
      lo  = int'($urandom_range(3, 6));
      hi  = int'($urandom_range(3, 6));
      scl = 1'b0;
      sda = b;
      tick(lo);
      scl = 1'b1;
      tick(hi);
   endtask

   // Sends one word inside an open frame. The last bit is stepped cycle by
   // cycle: DONE is expected 3 cycles after the final scl rise, the word
   // visible one cycle later. Optionally asserts rd_ack during DONE.
   task automatic send_word(input logic [7:0] w, input bit ack_at_done);
      for (int i = 7; i >= 1; i--) begin
         send_bit(w[i]);
         if (i == 5) check("busy_mid_word", busy, 1);
      end
      scl = 1'b0;
      sda = w[0];
      tick(int'($urandom_range(3, 6)));
      scl = 1'b1;
      tick(2);
      check("busy_before_done", busy, 1);
      tick(1);
      check("busy_in_done", busy, 0);
      if (!model_valid) check("valid_latency", valid, 0);
      if (ack_at_done) rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
      check("data_out", data_out, w);
      check("valid", valid, 1);
      if (model_valid && !ack_at_done) exp_ovr++;
      model_valid = 1'b1;
   endtask

   task automatic ack_word();
      rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
      check("valid_after_ack", valid, 0);
      model_valid = 1'b0;
   endtask

   task automatic end_frame();
      cs  = 1'b1;
      scl = 1'b1;
      sda = 1'b1;
      tick(6);
   endtask

   initial begin
      logic [7:0] w;
      int         n, mode;

      // Reset state
      tick(3);
      check("rst_data_out", data_out, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b1;
      tick(3);

      // Word left unacknowledged, then reset in the middle of the next frame
      cs = 1'b0;
      send_word(8'hA5, 1'b0);
      end_frame();
      cs = 1'b0;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      check("busy_before_reset", busy, 1);
      reset = 1'b0;
      #1;
      check("async_rst_data_out", data_out, 0);
      check("async_rst_valid", valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_frame_err", frame_err, 0);
      check("async_rst_overrun", overrun, 0);
      cs  = 1'b1;
      scl = 1'b1;
      sda = 1'b1;
      model_valid = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(3);

      // Basic word after reset
      cs = 1'b0;
      send_word(8'hE2, 1'b0);
      end_frame();
      ack_word();
      check("no_frame_err_after_reset", ferr_cyc, exp_ferr);

      // Back-to-back with acks
      cs = 1'b0;
      send_word(8'hE2, 1'b0);
      ack_word();
      send_word(8'h5A, 1'b0);
      ack_word();
      end_frame();
      check("b2b_no_overrun", ovr_cyc, exp_ovr);

      // Overrun: two words, no ack
      cs = 1'b0;
      send_word(8'hE2, 1'b0);
      send_word(8'h5A, 1'b0);
      end_frame();
      check("overrun_count", ovr_cyc, exp_ovr);
      check("overrun_data", data_out, 8'h5A);
      check("overrun_valid", valid, 1);

      // Framing error with a word still pending
      cs = 1'b0;
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      cs = 1'b1;
      exp_ferr++;
      tick(6);
      check("frame_err_pulse", ferr_cyc, exp_ferr);
      check("frame_err_valid_kept", valid, 1);
      check("frame_err_data_kept", data_out, 8'h5A);
      check("frame_err_idle", busy, 0);
      ack_word();
      cs = 1'b0;
      send_word(8'h81, 1'b0);
      end_frame();
      ack_word();

      // rd_ack in the DONE cycle of the second word
      cs = 1'b0;
      send_word(8'h3C, 1'b0);
      send_word(8'hC7, 1'b1);
      end_frame();
      check("collision_no_overrun", ovr_cyc, exp_ovr);
      check("collision_valid", valid, 1);
      check("collision_data", data_out, 8'hC7);
      ack_word();

      // Randomized frames against the handshake model
      for (int f = 0; f < 6; f++) begin
         cs = 1'b0;
         n  = int'($urandom_range(1, 3));
         for (int k = 0; k < n; k++) begin
            w    = 8'($urandom);
            mode = int'($urandom_range(0, 2));
            send_word(w, mode == 2);
            if (mode == 1) ack_word();
         end
         end_frame();
         check("rand_overrun_count", ovr_cyc, exp_ovr);
         check("rand_valid", valid, 32'(model_valid));
      end

      check("final_frame_err_count", ferr_cyc, exp_ferr);
      check("final_overrun_count", ovr_cyc, exp_ovr);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- Serial receiver that pairs with spi_tx in the SPI path.
- Oversamples the scl/sda/cs lines from spi_tx with the local system clock and shifts in MSB-first words.
- Presents each completed parallel word through a valid/ack handshake to the downstream controller logic, e.g. the elevator floor or command decoder.
- Detects framing errors (cs released mid-word) and overrun (new word completes before the previous one is acknowledged).

Parameters:
- DATA_WIDTH, 8, bits per word, matching spi_tx.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (scl, sda, cs); minimum 2.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- scl  input  1  serial clock from spi_tx; asynchronous to clk.
- sda  input  1  serial data from spi_tx; sampled on scl rising edge.
- cs  input  1  chip select, active-low; 0 = frame active.
- rd_ack  input  1  downstream consumed data_out; meaningful only while valid=1.
- data_out  output  DATA_WIDTH  last completed word, MSB = first bit received.
- valid  output  1  data_out holds an unacknowledged word.
- frame_err  output  1  one-cycle pulse: cs deasserted with 1..DATA_WIDTH-1 bits shifted.
- overrun  output  1  one-cycle pulse: word completed while valid=1.
- busy  output  1  high while in state RECV.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - data_out=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Shift register = 0, bit_cnt = 0, state = IDLE.
  - Synchronizers load idle levels: scl=1, sda=1, cs=1.
- Input conditioning:
  - scl, sda and cs each pass through SYNC_STAGES flops.
  - scl_rise = synchronized scl is 1 now and was 0 the previous cycle.
  - Event latency from a pin edge to internal action is SYNC_STAGES+1 clk cycles.
  - Constraint: the scl high and low phases must each last at least SYNC_STAGES+1 clk periods.
- FSM states: IDLE, RECV, DONE.
- IDLE:
  - busy=0, bit_cnt=0.
  - Synchronized cs=0 → RECV.
- RECV:
  - busy=1.
  - On scl_rise: shift = {shift[DATA_WIDTH-2:0], sda_sync}, bit_cnt++.
  - When the shift brings bit_cnt to DATA_WIDTH → DONE on the next cycle. The shift register holds the full word.
  - cs_sync=1 with bit_cnt=0 → IDLE silently.
  - cs_sync=1 with 0 < bit_cnt < DATA_WIDTH → frame_err pulses 1 cycle, shift is discarded, → IDLE.
  - scl_rise and cs release in the same cycle: the cs release wins and the bit is not shifted.
- DONE (exactly 1 cycle):
  - data_out ← shift, valid ← 1.
  - If valid was already 1 and rd_ack is not asserted this cycle: overrun pulses and data_out is overwritten with the new word.
  - bit_cnt ← 0.
  - cs_sync still 0 → RECV (back-to-back words in one frame); else → IDLE.
- Handshake:
  - valid stays 1 until a cycle with rd_ack=1, then clears on the next edge.
  - rd_ack while valid=0 is ignored.
  - rd_ack in the same cycle as DONE: the new word is loaded, valid stays 1, no overrun.
- bit_cnt width: clog2(DATA_WIDTH)+1. It never wraps; it is cleared on DONE and on IDLE.
- busy falls the cycle the state leaves RECV. Any edge arriving during DONE is lost.
- Constraint: the next scl rise must be ≥2 clk cycles after a word's final scl_rise.

Decomposition:
- Shared package spi_pkg:
  - State encoding constants: IDLE=2'd0, RECV=2'd1, DONE=2'd2.
  - SPI_DATA_WIDTH default 8, used by both spi_tx and spi_rx.
- One sub-module, spi_sync:
  - Parameterised SYNC_STAGES synchronizer with reset value.
  - Optional rise/fall edge-detect outputs.
  - Instantiated three times (scl, sda, cs).

Test Plan:
1. Reset mid-frame: reset=0 after 4 bits are shifted → all outputs 0 immediately (asynchronous). After release, a full word 0xE2 is received correctly with no frame_err.
2. Basic word: loop back spi_tx with data_in=8'b11100010 and cs=0 → valid rises SYNC_STAGES+2 cycles after the 8th scl rise with data_out=0xE2. busy=1 during the shift. rd_ack pulse → valid=0 the next cycle.
3. Back-to-back: cs held 0, words 0xE2 then 0x5A, rd_ack pulsed after each → two valid events with data_out=0xE2 then 0x5A, overrun never pulses.
4. Overrun: two words with no rd_ack → overrun pulses exactly once at the second DONE, data_out=0x5A, valid stays 1.
5. Framing error: cs raised after 3 bits → frame_err 1-cycle pulse, valid unchanged, state IDLE. The next full frame 0x81 is received correctly.
6. Ack/DONE collision: assert rd_ack in the exact DONE cycle of the second word → no overrun, valid=1, data_out=second word.
